wb_commit_stage: RTL and testbench

//  Dual-issue MEM/WB pipeline register plus write-back commit logic.

---
 rtl/wb_commit_stage.sv | 122 ++++++++++++
 tb/tb_wb_commit_stage.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/wb_commit_stage.sv
// Dual-issue MEM/WB pipeline register with write-back commit logic.
// It resolves same-destination pairs, compacts single writes onto port 1, and counts retired instructions.
module wb_commit_stage #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              l1_valid,
   input  logic              l1_regwrite,
   input  logic              l1_memtoreg,
   input  logic [ADDR_W-1:0] l1_rd,
   input  logic [DATA_W-1:0] l1_alu_result,
   input  logic [DATA_W-1:0] l1_mem_data,
   input  logic              l2_valid,
   input  logic              l2_regwrite,
   input  logic              l2_memtoreg,
   input  logic [ADDR_W-1:0] l2_rd,
   input  logic [DATA_W-1:0] l2_alu_result,
   input  logic [DATA_W-1:0] l2_mem_data,
   output logic              we1,
   output logic              we2,
   output logic [ADDR_W-1:0] writeRegister1,
   output logic [ADDR_W-1:0] writeRegister2,
   output logic [DATA_W-1:0] writeData1,
   output logic [DATA_W-1:0] writeData2,
   output logic [CNT_W-1:0]  retire_count
);

   typedef struct packed {
      logic              valid;
      logic              regwrite;
      logic              memtoreg;
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] mem;
   } lane_t;

   lane_t            lane1_q, lane1_d;
   lane_t            lane2_q, lane2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [DATA_W-1:0] res1, res2;
   logic              eff1, eff2;

   // NOTE: every always_comb output is given a default first, so no path can infer a latch.
   always_comb begin
      lane1_d = lane1_q;
      lane2_d = lane2_q;
      cnt_d   = cnt_q;
      if (flush) begin
         lane1_d.valid = 1'b0;
         lane2_d.valid = 1'b0;
      end else if (!stall) begin
         lane1_d = '{valid: l1_valid, regwrite: l1_regwrite, memtoreg: l1_memtoreg,
                     rd: l1_rd, alu: l1_alu_result, mem: l1_mem_data};
         lane2_d = '{valid: l2_valid, regwrite: l2_regwrite, memtoreg: l2_memtoreg,
                     rd: l2_rd, alu: l2_alu_result, mem: l2_mem_data};
         cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, l1_valid} + {{(CNT_W-1){1'b0}}, l2_valid};
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane1_q <= '0;
         lane2_q <= '0;
         cnt_q   <= '0;
      end else begin
         lane1_q <= lane1_d;
         lane2_q <= lane2_d;
         cnt_q   <= cnt_d;
      end
   end

   assign res1 = lane1_q.memtoreg ? lane1_q.mem : lane1_q.alu;
   assign res2 = lane2_q.memtoreg ? lane2_q.mem : lane2_q.alu;
   assign eff1 = lane1_q.valid & lane1_q.regwrite & (|lane1_q.rd);
   assign eff2 = lane2_q.valid & lane2_q.regwrite & (|lane2_q.rd);

   // Port 2 is only honoured alongside port 1, so a lone write always uses port 1.
   always_comb begin
      we1            = 1'b0;
      we2            = 1'b0;
      writeRegister1 = '0;
      writeRegister2 = '0;
      writeData1     = '0;
      writeData2     = '0;
      case ({eff1, eff2})
         2'b11: begin
            we1 = 1'b1;
            if (lane1_q.rd == lane2_q.rd) begin
               writeRegister1 = lane2_q.rd;
               writeData1     = res2;
            end else begin
               writeRegister1 = lane1_q.rd;
               writeData1     = res1;
               we2            = 1'b1;
               writeRegister2 = lane2_q.rd;
               writeData2     = res2;
            end
         end
         2'b10: begin
            we1            = 1'b1;
            writeRegister1 = lane1_q.rd;
            writeData1     = res1;
         end
         2'b01: begin
            we1            = 1'b1;
            writeRegister1 = lane2_q.rd;
            writeData1     = res2;
         end
         default: ;
      endcase
   end

   assign retire_count = cnt_q;

endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed bench for wb_commit_stage: a vector table plus hand-written stall, reset and wrap sequences.
module tb_wb_commit_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, flush;
   logic        l1_valid, l1_regwrite, l1_memtoreg;
   logic [4:0]  l1_rd;
   logic [31:0] l1_alu_result, l1_mem_data;
   logic        l2_valid, l2_regwrite, l2_memtoreg;
   logic [4:0]  l2_rd;
   logic [31:0] l2_alu_result, l2_mem_data;

   logic        we1, we2;
   logic [4:0]  writeRegister1, writeRegister2;
   logic [31:0] writeData1, writeData2;
   logic [31:0] retire_count;

   logic        s_we1, s_we2;
   logic [4:0]  s_wr1, s_wr2;
   logic [31:0] s_wd1, s_wd2;
   logic [3:0]  s_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   wb_commit_stage u_dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .l1_valid(l1_valid), .l1_regwrite(l1_regwrite), .l1_memtoreg(l1_memtoreg),
      .l1_rd(l1_rd), .l1_alu_result(l1_alu_result), .l1_mem_data(l1_mem_data),
      .l2_valid(l2_valid), .l2_regwrite(l2_regwrite), .l2_memtoreg(l2_memtoreg),
      .l2_rd(l2_rd), .l2_alu_result(l2_alu_result), .l2_mem_data(l2_mem_data),
      .we1(we1), .we2(we2), .writeRegister1(writeRegister1), .writeRegister2(writeRegister2),
      .writeData1(writeData1), .writeData2(writeData2), .retire_count(retire_count)
   );

   wb_commit_stage #(.CNT_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .l1_valid(l1_valid), .l1_regwrite(l1_regwrite), .l1_memtoreg(l1_memtoreg),
      .l1_rd(l1_rd), .l1_alu_result(l1_alu_result), .l1_mem_data(l1_mem_data),
      .l2_valid(l2_valid), .l2_regwrite(l2_regwrite), .l2_memtoreg(l2_memtoreg),
      .l2_rd(l2_rd), .l2_alu_result(l2_alu_result), .l2_mem_data(l2_mem_data),
      .we1(s_we1), .we2(s_we2), .writeRegister1(s_wr1), .writeRegister2(s_wr2),
      .writeData1(s_wd1), .writeData2(s_wd2), .retire_count(s_cnt)
   );

   typedef struct {
      logic        stall, flush;
      logic        v1, rw1, mt1;
      logic [4:0]  rd1;
      logic [31:0] alu1, mem1;
      logic        v2, rw2, mt2;
      logic [4:0]  rd2;
      logic [31:0] alu2, mem2;
      logic        e_we1, e_we2;
      logic [4:0]  e_wr1, e_wr2;
      logic [31:0] e_wd1, e_wd2;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic st, input logic fl,
                        input logic v1, input logic rw1, input logic mt1, input logic [4:0] rd1,
                        input logic [31:0] alu1, input logic [31:0] mem1,
                        input logic v2, input logic rw2, input logic mt2, input logic [4:0] rd2,
                        input logic [31:0] alu2, input logic [31:0] mem2);
      stall = st; flush = fl;
      l1_valid = v1; l1_regwrite = rw1; l1_memtoreg = mt1; l1_rd = rd1;
      l1_alu_result = alu1; l1_mem_data = mem1;
      l2_valid = v2; l2_regwrite = rw2; l2_memtoreg = mt2; l2_rd = rd2;
      l2_alu_result = alu2; l2_mem_data = mem2;
   endtask

   task automatic check_ports(input string tag, input logic e_we1, input logic [4:0] e_wr1,
                              input logic [31:0] e_wd1, input logic e_we2, input logic [4:0] e_wr2,
                              input logic [31:0] e_wd2, input logic [31:0] e_cnt);
      check({tag, ".we1"}, {63'd0, we1}, {63'd0, e_we1});
      check({tag, ".wr1"}, {59'd0, writeRegister1}, {59'd0, e_wr1});
      check({tag, ".wd1"}, {32'd0, writeData1}, {32'd0, e_wd1});
      check({tag, ".we2"}, {63'd0, we2}, {63'd0, e_we2});
      check({tag, ".wr2"}, {59'd0, writeRegister2}, {59'd0, e_wr2});
      check({tag, ".wd2"}, {32'd0, writeData2}, {32'd0, e_wd2});
      check({tag, ".cnt"}, {32'd0, retire_count}, {32'd0, e_cnt});
   endtask

   initial begin
      //          st fl  v1 rw mt rd alu1          mem1          v2 rw mt rd alu2          mem2          we1 we2 wr1 wr2 wd1           wd2           cnt
      vecs[0]  = '{0, 0, 1, 1, 0, 3, 32'h11,       32'hDEAD,     1, 1, 1, 4, 32'h99,       32'hAB,       1, 1, 3,  4, 32'h11,       32'hAB,       2};
      vecs[1]  = '{0, 0, 1, 1, 0, 7, 32'h1,        32'h0,        1, 1, 0, 7, 32'h2,        32'h0,        1, 0, 7,  0, 32'h2,        32'h0,        4};
      vecs[2]  = '{0, 0, 1, 1, 0, 0, 32'h77,       32'h0,        1, 1, 0, 9, 32'h55,       32'h0,        1, 0, 9,  0, 32'h55,       32'h0,        6};
      vecs[3]  = '{0, 0, 1, 1, 0, 0, 32'h5,        32'h0,        1, 1, 0, 0, 32'h6,        32'h0,        0, 0, 0,  0, 32'h0,        32'h0,        8};
      vecs[4]  = '{0, 0, 1, 1, 1, 5, 32'h3,        32'h1234,     1, 0, 0, 6, 32'h66,       32'h0,        1, 0, 5,  0, 32'h1234,     32'h0,        10};
      vecs[5]  = '{0, 0, 0, 1, 0, 8, 32'h88,       32'h0,        1, 1, 0, 10, 32'hCAFE,    32'h0,        1, 0, 10, 0, 32'hCAFE,     32'h0,        11};
      vecs[6]  = '{0, 0, 0, 1, 0, 8, 32'h88,       32'h0,        0, 1, 0, 10, 32'hCAFE,    32'h0,        0, 0, 0,  0, 32'h0,        32'h0,        11};
      vecs[7]  = '{0, 1, 1, 1, 0, 3, 32'h33,       32'h0,        1, 1, 0, 4, 32'h44,       32'h0,        0, 0, 0,  0, 32'h0,        32'h0,        11};
      vecs[8]  = '{0, 0, 1, 1, 0, 31, 32'hFFFFFFFF, 32'h0,       1, 1, 1, 1, 32'h0,        32'h80000000, 1, 1, 31, 1, 32'hFFFFFFFF, 32'h80000000, 13};
      vecs[9]  = '{1, 0, 1, 1, 0, 20, 32'h2020,    32'h0,        1, 1, 0, 21, 32'h2121,    32'h0,        1, 1, 31, 1, 32'hFFFFFFFF, 32'h80000000, 13};
      vecs[10] = '{1, 1, 1, 1, 0, 20, 32'h2020,    32'h0,        1, 1, 0, 21, 32'h2121,    32'h0,        0, 0, 0,  0, 32'h0,        32'h0,        13};

      // Reset held with random inputs toggling across edges.
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
               $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
               $urandom, $urandom);
         @(posedge clk); #1;
      end
      check_ports("reset", 0, 0, 0, 0, 0, 0, 0);
      check("reset.cnt4", {60'd0, s_cnt}, 64'd0);

      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].stall, vecs[i].flush,
               vecs[i].v1, vecs[i].rw1, vecs[i].mt1, vecs[i].rd1, vecs[i].alu1, vecs[i].mem1,
               vecs[i].v2, vecs[i].rw2, vecs[i].mt2, vecs[i].rd2, vecs[i].alu2, vecs[i].mem2);
         @(posedge clk); #1;
         check_ports($sformatf("v%0d", i), vecs[i].e_we1, vecs[i].e_wr1, vecs[i].e_wd1,
                     vecs[i].e_we2, vecs[i].e_wr2, vecs[i].e_wd2, vecs[i].e_cnt);
         check($sformatf("v%0d.inv", i), {63'd0, (we2 && (!we1 || writeRegister1 == writeRegister2))}, 64'd0);
      end

      // Dual load, then a three-cycle stall that must repeat the same write.
      drive(0, 0, 1, 1, 0, 12, 32'hA, 32'h0, 1, 1, 1, 13, 32'h0, 32'hB);
      @(posedge clk); #1;
      check_ports("preStall", 1, 12, 32'hA, 1, 13, 32'hB, 15);
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 1, 1, 0, 14, 32'hE, 32'h0, 1, 1, 0, 15, 32'hF, 32'h0);
         @(posedge clk); #1;
         check_ports($sformatf("stall%0d", i), 1, 12, 32'hA, 1, 13, 32'hB, 15);
      end

      // Asynchronous reset in mid-cycle drops the in-flight write at once.
      drive(0, 0, 1, 1, 0, 2, 32'h42, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0);
      @(posedge clk); #1;
      check_ports("preRst", 1, 2, 32'h42, 0, 0, 0, 16);
      #3;
      rst = 1'b1;
      #1;
      check_ports("asyncRst", 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      // Narrow counter: 15 single-issue loads, then one dual load wraps to 1.
      drive(0, 0, 1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0);
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
      end
      check("wrap.pre4", {60'd0, s_cnt}, 64'd15);
      check("wrap.pre32", {32'd0, retire_count}, 64'd15);
      drive(0, 0, 1, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 32'h0, 32'h0);
      @(posedge clk); #1;
      check("wrap.cnt4", {60'd0, s_cnt}, 64'd1);
      check("wrap.cnt32", {32'd0, retire_count}, 64'd17);
      check("wrap.we1", {63'd0, s_we1}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
